// File: rtl/tube_host_pkg.sv
// tube_host_pkg: shared FSM encoding, HRW levels, host register indices and cycle-count saturation.
package tube_host_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, STROBE = 2'd2, HOLD = 2'd3} state_e;
  localparam logic HRW_READ  = 1'b1;
  localparam logic HRW_WRITE = 1'b0;
  localparam logic [2:0] HA_R0 = 3'd0, HA_R1 = 3'd1, HA_R2 = 3'd2, HA_R3 = 3'd3;
  localparam logic [2:0] HA_R4 = 3'd4, HA_R5 = 3'd5, HA_R6 = 3'd6, HA_R7 = 3'd7;
  function automatic logic [3:0] sat_cycles(input int n);
    return n < 1 ? 4'd1 : n > 15 ? 4'd15 : 4'(n);
  endfunction
endpackage

// File: rtl/tube_host_bus_master_if.sv
// tube_host_bus_master_if: command/response handshake plus Tube host bus pins.
interface tube_host_bus_master_if;
  logic       cmd_valid, cmd_ready, cmd_rw;
  logic [2:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic [2:0] HA;
  logic       HCS, HRW, HDOE;
  logic [7:0] HD_O, HD_I;
  modport master (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, HD_I, HDOE,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, HA, HCS, HRW, HD_O
  );
  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, HD_I, HDOE,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, HA, HCS, HRW, HD_O
  );
endinterface

// File: rtl/tube_host_cycle_timer.sv
// tube_host_cycle_timer: loadable 4-bit down-counter that stops at zero; done while zero.
module tube_host_cycle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_val,
  output logic       done
);
  logic [3:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (en && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
  always_ff @(posedge clk)
    if (!rst_n) cnt_q <= 4'd0;
    else cnt_q <= cnt_d;
  assign done = cnt_q == 4'd0;
endmodule

// File: rtl/tube_host_bus_master.sv
// tube_host_bus_master: turns single commands into Tube host bus cycles.
// Define TUBE_HOST_STATS_EN to add saturating read/write/error counters.
module tube_host_bus_master
  import tube_host_pkg::*;
#(
  parameter int SETUP_CYCLES = 1,
  parameter int HOLD_CYCLES  = 3,
  parameter bit INVERT_WDATA = 1'b1
) (
  input  logic                   HO2,
  input  logic                   HRST,
  tube_host_bus_master_if.master bus
`ifdef TUBE_HOST_STATS_EN
  ,
  output logic [15:0]            stat_reads,
  output logic [15:0]            stat_writes,
  output logic [15:0]            stat_errs
`endif
);
  localparam logic [3:0] SETUP_LD = sat_cycles(SETUP_CYCLES) - 4'd1;
  localparam logic [3:0] HOLD_LD  = sat_cycles(HOLD_CYCLES) - 4'd1;
  state_e     state_q, state_d;
  logic [2:0] ha_q, ha_d;
  logic [7:0] hd_q, hd_d, rsp_rdata_q, rsp_rdata_d;
  logic       hcs_q, hcs_d, hrw_q, hrw_d, cmd_ready_q, cmd_ready_d;
  logic       rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic       t_load, t_en, t_done;
  logic [3:0] t_val;
  tube_host_cycle_timer u_timer (
    .clk(HO2), .rst_n(HRST), .load(t_load), .en(t_en), .load_val(t_val), .done(t_done)
  );
  always_comb begin
    state_d     = state_q;
    ha_d        = ha_q;
    hrw_d       = hrw_q;
    hd_d        = hd_q;
    hcs_d       = 1'b1;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    t_load      = 1'b0;
    t_en        = 1'b0;
    t_val       = SETUP_LD;
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        state_d = SETUP;
        ha_d    = bus.cmd_addr;
        hrw_d   = bus.cmd_rw;
        hd_d    = bus.cmd_rw == HRW_READ ? 8'h00 : INVERT_WDATA ? ~bus.cmd_wdata : bus.cmd_wdata;
        t_load  = 1'b1;
      end
      SETUP: begin
        t_en = 1'b1;
        if (t_done) begin
          state_d = STROBE;
          hcs_d   = 1'b0;
        end
      end
      STROBE: begin
        state_d     = HOLD;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = hrw_q == HRW_READ ? bus.HD_I : 8'h00;
        rsp_err_d   = hrw_q == HRW_READ && !bus.HDOE;
        t_load      = 1'b1;
        t_val       = HOLD_LD;
      end
      HOLD: begin
        t_en = 1'b1;
        if (t_done) begin
          state_d = IDLE;
          hrw_d   = 1'b1;
          hd_d    = 8'h00;
        end
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = state_d == IDLE;
  end
  always_ff @(posedge HO2)
    if (!HRST) begin
      state_q     <= IDLE;
      ha_q        <= 3'd0;
      hrw_q       <= 1'b1;
      hd_q        <= 8'h00;
      hcs_q       <= 1'b1;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ha_q        <= ha_d;
      hrw_q       <= hrw_d;
      hd_q        <= hd_d;
      hcs_q       <= hcs_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.HA        = ha_q;
  assign bus.HCS       = hcs_q;
  assign bus.HRW       = hrw_q;
  assign bus.HD_O      = hd_q;
`ifdef TUBE_HOST_STATS_EN
  // hrw_q still holds the command direction during the rsp_valid cycle
  logic [15:0] stat_reads_q, stat_reads_d, stat_writes_q, stat_writes_d, stat_errs_q, stat_errs_d;
  always_comb begin
    stat_reads_d  = stat_reads_q + 16'(rsp_valid_q && hrw_q == HRW_READ && stat_reads_q != 16'hFFFF);
    stat_writes_d = stat_writes_q + 16'(rsp_valid_q && hrw_q == HRW_WRITE && stat_writes_q != 16'hFFFF);
    stat_errs_d   = stat_errs_q + 16'(rsp_valid_q && rsp_err_q && stat_errs_q != 16'hFFFF);
  end
  always_ff @(posedge HO2)
    if (!HRST) begin
      stat_reads_q  <= 16'h0;
      stat_writes_q <= 16'h0;
      stat_errs_q   <= 16'h0;
    end else begin
      stat_reads_q  <= stat_reads_d;
      stat_writes_q <= stat_writes_d;
      stat_errs_q   <= stat_errs_d;
    end
  assign stat_reads  = stat_reads_q;
  assign stat_writes = stat_writes_q;
  assign stat_errs   = stat_errs_q;
`endif
endmodule
